// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its fetch/data requesters and the shared memory.
// slave: the arbiter's view; master: the requester/memory side that drives it.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_addr, mem_wdata,
           mem_read, mem_write, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_addr, mem_wdata,
           mem_read, mem_write, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between fetch and data ports; data wins ties until its streak limit.
// Access holds the strobe WAIT_STATES+1 cycles; requesters hold req until their 1-cycle ready.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned MAX_DSTREAK = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_STATES);
  localparam logic [2:0] STREAK_MAX = 3'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [2:0]  streak_q, streak_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        if_ok, d_ok;

  // In a port's ready cycle its req still belongs to the finished access, so skip it.
  assign if_ok = bus.if_req & ~if_ready_q;
  assign d_ok  = bus.d_req & ~d_ready_q;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    streak_d   = streak_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_ok && !(if_ok && streak_q == STREAK_MAX)) begin
          state_d = D_ACC;
          we_d    = bus.d_we;
          addr_d  = bus.d_addr;
          wait_d  = 4'd0;
          if (bus.d_we) wdata_d = bus.d_wdata;
          if (bus.if_req && streak_q < STREAK_MAX) streak_d = streak_q + 3'd1;
        end else if (if_ok) begin
          state_d  = IF_ACC;
          we_d     = 1'b0;
          addr_d   = bus.if_addr;
          wait_d   = 4'd0;
          streak_d = 3'd0;
        end
      end
      IF_ACC, D_ACC: begin
        if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          if (state_q == IF_ACC) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            if (!we_q) d_rdata_d = bus.mem_rdata;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= 4'd0;
      streak_q   <= 3'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      streak_q   <= streak_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.mem_read  = (state_q == IF_ACC) | ((state_q == D_ACC) & ~we_q);
  assign bus.mem_write = (state_q == D_ACC) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall     = bus.if_req & ~if_ready_q;
endmodule
